// File: rtl/kij_pass_sequencer.sv
`default_nettype none
// ============================================================================
// kij_pass_sequencer - steps core inst through every kernel position (kij):
// weight SRAM->L0, L0->PE load, settle gap, execute, OFIFO drain to psum SRAM.
// Build option: KIJ_SEQ_WATCHDOG_EN adds a DRAIN stall watchdog + timeout.
// Rev 1.0
// ============================================================================
module kij_pass_sequencer #(
   parameter int ROW            = 8,
   parameter int COL            = 8,
   parameter int LEN_NIJ        = 36,
   parameter int IN_W           = 6,
   parameter int OUT_W          = 4,
   parameter int KW             = 3,
   parameter int ADDR_W         = 11,
   parameter int W_BASE         = 1024,
   parameter int PSUM_OC_STRIDE = 32,
   parameter int GAP_CYCLES     = 11
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        oc_group,
   input  logic        ofifo_valid,
   output logic [36:0] inst,
   output logic        busy,
   output logic        done,
   output logic [3:0]  cur_kij
`ifdef KIJ_SEQ_WATCHDOG_EN
   ,
   output logic        timeout
`endif
);

   localparam int CNT_W = 7;
   localparam int XY_W  = 4;
   localparam int DR_W  = 7;

   localparam logic [2:0] c_S_IDLE  = 3'd0;
   localparam logic [2:0] c_S_WL0   = 3'd1;
   localparam logic [2:0] c_S_WLOAD = 3'd2;
   localparam logic [2:0] c_S_GAP   = 3'd3;
   localparam logic [2:0] c_S_EXEC  = 3'd4;
   localparam logic [2:0] c_S_DRAIN = 3'd5;
   localparam logic [2:0] c_S_FLUSH = 3'd6;

   localparam logic [CNT_W-1:0] c_WL0_LAST   = CNT_W'(COL + 1);
   localparam logic [CNT_W-1:0] c_WLOAD_LAST = CNT_W'(COL + ROW);
   localparam logic [CNT_W-1:0] c_GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] c_EXEC_LAST  = CNT_W'(LEN_NIJ);
   localparam logic [CNT_W-1:0] c_FLUSH_LAST = CNT_W'(2);
   localparam logic [DR_W-1:0]  c_LEN        = DR_W'(LEN_NIJ);
   localparam logic [3:0]       c_KIJ_LAST   = 4'(KW * KW - 1);
   localparam logic [XY_W-1:0]  c_IN_LAST    = XY_W'(IN_W - 1);
   localparam logic [XY_W-1:0]  c_KW_LAST    = XY_W'(KW - 1);
   localparam logic [XY_W-1:0]  c_OUT_W      = XY_W'(OUT_W);
   localparam logic [36:0]      c_INST_IDLE  = 37'h1_000C_0000;

   logic [2:0]        r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [3:0]        r_kij;
   logic [XY_W-1:0]   r_kx;
   logic [XY_W-1:0]   r_ky;
   logic              r_oc;
   logic [DR_W-1:0]   r_drained;
   logic [XY_W-1:0]   r_nijx;
   logic [XY_W-1:0]   r_nijy;
   logic [36:0]       r_inst;
   logic              r_busy;
   logic              r_done;

   logic [2:0]        w_state_nxt;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic [3:0]        w_kij_nxt;
   logic              w_done_nxt;
   logic              w_to_nxt;
   logic              w_drain;
   logic [XY_W-1:0]   w_ox;
   logic [XY_W-1:0]   w_oy;
   logic              w_x_ok;
   logic              w_y_ok;
   logic              w_pvalid;
   logic [ADDR_W-1:0] w_apmem;
   logic [ADDR_W-1:0] w_wbase;
   logic [36:0]       w_inst_nxt;

   assign inst    = r_inst;
   assign busy    = r_busy;
   assign done    = r_done;
   assign cur_kij = r_kij;

   // Drained rows walk the input tile; shift by kernel offset to land on onij.
   assign w_drain  = ((r_state == c_S_EXEC) || (r_state == c_S_DRAIN)) && ofifo_valid
                     && (r_drained < c_LEN);
   assign w_ox     = r_nijx - r_kx;
   assign w_oy     = r_nijy - r_ky;
   assign w_x_ok   = (r_nijx >= r_kx) && (w_ox < c_OUT_W);
   assign w_y_ok   = (r_nijy >= r_ky) && (w_oy < c_OUT_W);
   assign w_pvalid = w_drain && w_x_ok && w_y_ok;
   assign w_apmem  = ADDR_W'(w_oy) * ADDR_W'(OUT_W) + ADDR_W'(w_ox)
                     + (r_oc ? ADDR_W'(PSUM_OC_STRIDE) : '0);
   assign w_wbase  = ADDR_W'(W_BASE) + ADDR_W'(w_kij_nxt) * ADDR_W'(COL);

`ifdef KIJ_SEQ_WATCHDOG_EN
   logic [9:0] r_wd;
   logic [9:0] w_wd_nxt;
   logic       r_timeout;

   assign timeout  = r_timeout;
   assign w_wd_nxt = (r_state != c_S_DRAIN) ? 10'd0 :
                     (ofifo_valid ? 10'd0 : r_wd + 10'd1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wd      <= 10'd0;
         r_timeout <= 1'b0;
      end else begin
         r_wd      <= w_wd_nxt;
         r_timeout <= w_to_nxt;
      end
   end
`endif

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= c_S_IDLE;
         r_cnt   <= '0;
         r_kij   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_inst  <= c_INST_IDLE;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_kij   <= w_kij_nxt;
         r_busy  <= (w_state_nxt != c_S_IDLE);
         r_done  <= w_done_nxt;
         r_inst  <= w_inst_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt + 1'b1;
      w_kij_nxt   = r_kij;
      w_done_nxt  = 1'b0;
      w_to_nxt    = 1'b0;
      case (r_state)
         c_S_IDLE: begin
            w_cnt_nxt = '0;
            if (start) begin
               w_state_nxt = c_S_WL0;
               w_kij_nxt   = '0;
            end
         end
         c_S_WL0: if (r_cnt == c_WL0_LAST) begin
            w_state_nxt = c_S_WLOAD;
            w_cnt_nxt   = '0;
         end
         c_S_WLOAD: if (r_cnt == c_WLOAD_LAST) begin
            w_state_nxt = c_S_GAP;
            w_cnt_nxt   = '0;
         end
         c_S_GAP: if (r_cnt == c_GAP_LAST) begin
            w_state_nxt = c_S_EXEC;
            w_cnt_nxt   = '0;
         end
         c_S_EXEC: if (r_cnt == c_EXEC_LAST) begin
            w_state_nxt = c_S_DRAIN;
            w_cnt_nxt   = '0;
         end
         c_S_DRAIN: begin
            // Leave one cycle after the last row so its pmem write shows here.
            w_cnt_nxt = '0;
            if (r_drained == c_LEN) begin
               w_state_nxt = c_S_FLUSH;
            end
`ifdef KIJ_SEQ_WATCHDOG_EN
            else if (w_wd_nxt == 10'd512) begin
               w_state_nxt = c_S_IDLE;
               w_to_nxt    = 1'b1;
            end
`endif
         end
         c_S_FLUSH: if (r_cnt == c_FLUSH_LAST) begin
            w_cnt_nxt = '0;
            if (r_kij == c_KIJ_LAST) begin
               w_state_nxt = c_S_IDLE;
               w_done_nxt  = 1'b1;
            end else begin
               w_state_nxt = c_S_WL0;
               w_kij_nxt   = r_kij + 1'b1;
            end
         end
         default: begin
            w_state_nxt = c_S_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // Output logic: inst for the upcoming cycle, plus this cycle's drain decision
   always_comb begin
      w_inst_nxt = c_INST_IDLE;
      case (w_state_nxt)
         c_S_WL0: begin
            w_inst_nxt[19]   = 1'b0;
            w_inst_nxt[17:7] = w_wbase + ((w_cnt_nxt == '0) ? '0 : ADDR_W'(w_cnt_nxt - 1'b1));
            w_inst_nxt[2]    = (w_cnt_nxt != '0);
         end
         c_S_WLOAD: begin
            w_inst_nxt[3] = 1'b1;
            w_inst_nxt[0] = (w_cnt_nxt != '0);
         end
         c_S_EXEC: begin
            w_inst_nxt[19]   = 1'b0;
            w_inst_nxt[17:7] = ADDR_W'(w_cnt_nxt);
            w_inst_nxt[3]    = 1'b1;
            w_inst_nxt[2]    = 1'b1;
            w_inst_nxt[1]    = (w_cnt_nxt != '0);
         end
         default: ;
      endcase
      if (w_drain) begin
         w_inst_nxt[6]  = 1'b1;
         w_inst_nxt[34] = (r_kij == '0);
         w_inst_nxt[33] = (r_kij != '0);
         if (w_pvalid) begin
            w_inst_nxt[32]    = 1'b0;
            w_inst_nxt[31]    = 1'b1;
            w_inst_nxt[30:20] = w_apmem;
         end
      end
   end

   // Drain position and kernel offset counters
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_oc      <= 1'b0;
         r_kx      <= '0;
         r_ky      <= '0;
         r_drained <= '0;
         r_nijx    <= '0;
         r_nijy    <= '0;
      end else if ((r_state == c_S_IDLE) && start) begin
         r_oc      <= oc_group;
         r_kx      <= '0;
         r_ky      <= '0;
         r_drained <= '0;
         r_nijx    <= '0;
         r_nijy    <= '0;
      end else if (r_state == c_S_FLUSH) begin
         r_drained <= '0;
         r_nijx    <= '0;
         r_nijy    <= '0;
         if (r_cnt == c_FLUSH_LAST) begin
            if (r_kx == c_KW_LAST) begin
               r_kx <= '0;
               r_ky <= r_ky + 1'b1;
            end else begin
               r_kx <= r_kx + 1'b1;
            end
         end
      end else if (w_drain) begin
         r_drained <= r_drained + 1'b1;
         if (r_nijx == c_IN_LAST) begin
            r_nijx <= '0;
            r_nijy <= r_nijy + 1'b1;
         end else begin
            r_nijx <= r_nijx + 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_kij_pass_sequencer.sv
`default_nettype none
// tb_kij_pass_sequencer - directed vectors and per-kij tallies for kij_pass_sequencer.
module tb_kij_pass_sequencer;
   logic        clk = 1'b0;
   logic        reset, start, oc_group, ofifo_valid;
   logic [36:0] inst;
   logic        busy, done;
   logic [3:0]  cur_kij;
`ifdef KIJ_SEQ_WATCHDOG_EN
   logic        timeout;
`endif

   kij_pass_sequencer dut (
      .clk(clk), .reset(reset), .start(start), .oc_group(oc_group),
      .ofifo_valid(ofifo_valid), .inst(inst), .busy(busy), .done(done),
      .cur_kij(cur_kij)
`ifdef KIJ_SEQ_WATCHDOG_EN
      , .timeout(timeout)
`endif
   );

   always #5 clk = ~clk;

   localparam logic [36:0] IDLE_PAT = 37'h1_000C_0000;

   typedef struct {
      int run; int kij; int nij; bit wr; int addr;
   } vec_t;
   vec_t vecs[18];

   int n_tests, n_fail;
   int run;
   int n_wl0[3][9], n_wload[3][9], n_load[3][9], n_exec[3][9], n_execute[3][9];
   int n_gap[3][9], n_flush[3][9], n_rd[3][9], n_wr[3][9], ax0[3][9];
   int n_done[3], done_kij[3], done_busy[3];
   bit dw[3][9][36], dsfu[3][9][36], dacc[3][9][36];
   int da[3][9][36];
   bit in_gap, armed, ofifo_en = 1'b1;
   int m_k, m_n, d_cyc, e_cyc;

   task automatic check(input string name, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic wait_for(input int sel, input string name);
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 3000 && !hit; i++) begin
         @(negedge clk);
         case (sel)
            0: hit = (cur_kij == 4'd3);
            1: hit = done;
            2: hit = inst[19] && inst[3];
            default: hit = 1'b0;
         endcase
      end
      if (!hit) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: got no event expected event within 3000 cycles", name);
      end
   endtask

   // Monitor: classify each cycle's inst and tally per run / kij
   initial begin
      forever begin
         @(negedge clk);
         if (!reset) begin
            m_k = int'(cur_kij);
            if (done) begin
               n_done[run]++;
               done_kij[run]  = m_k;
               done_busy[run] = int'(busy);
               if (run < 2) run++;
            end
            if (busy && m_k < 9) begin
               if (!inst[19] && !inst[3]) begin
                  if (n_wl0[run][m_k] == 0) ax0[run][m_k] = int'(inst[17:7]);
                  n_wl0[run][m_k]++;
                  in_gap = 1'b0;
               end
               if (inst[19] && inst[3]) begin
                  n_wload[run][m_k]++;
                  in_gap = 1'b1;
               end
               if (!inst[19] && inst[3]) begin
                  n_exec[run][m_k]++;
                  in_gap = 1'b0;
               end
               if (inst[0]) n_load[run][m_k]++;
               if (inst[1]) n_execute[run][m_k]++;
               if (inst == IDLE_PAT) begin
                  if (in_gap) n_gap[run][m_k]++;
                  if (n_rd[run][m_k] == 36) n_flush[run][m_k]++;
               end
               if (inst[6]) begin
                  m_n = n_rd[run][m_k];
                  if (m_n < 36) begin
                     dw[run][m_k][m_n]   = !inst[32] && inst[31];
                     da[run][m_k][m_n]   = int'(inst[30:20]);
                     dsfu[run][m_k][m_n] = inst[34];
                     dacc[run][m_k][m_n] = inst[33];
                  end
                  n_rd[run][m_k]++;
               end
               if (!inst[32] && inst[31]) n_wr[run][m_k]++;
            end
         end
      end
   end

   // OFIFO model: rows become valid 16 cycles after the first execute, 36 in a row
   initial begin
      ofifo_valid = 1'b0;
      forever begin
         @(negedge clk);
         if (reset || !busy || (!inst[19] && !inst[3])) armed = 1'b0;
         else if (inst[1] && !armed) begin
            armed = 1'b1;
            e_cyc = d_cyc;
         end
         ofifo_valid = ofifo_en && armed && (d_cyc - e_cyc >= 16) && (d_cyc - e_cyc <= 51);
         d_cyc++;
      end
   end

   initial begin
      int mask, bad, base;
      vecs = '{
         '{0,0,0,1,0},  '{0,0,3,1,3},  '{0,0,4,0,0},  '{0,0,6,1,4},  '{0,0,21,1,15},
         '{0,2,1,0,0},  '{0,2,2,1,0},  '{0,2,5,1,3},  '{0,4,0,0,0},  '{0,4,7,1,0},
         '{0,4,28,1,15},'{0,8,13,0,0}, '{0,8,14,1,0}, '{0,8,35,1,15},
         '{1,0,0,1,32}, '{1,0,21,1,47},'{1,4,7,1,32}, '{1,8,35,1,47}
      };
      reset = 1'b1; start = 1'b0; oc_group = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_inst", inst, IDLE_PAT);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_kij", cur_kij, 0);
      reset = 1'b0;
      @(negedge clk);

      // Run 0: oc_group 0, with a start pulse injected mid-run
      start = 1'b1; oc_group = 1'b0;
      @(negedge clk);
      start = 1'b0;
      check("busy_after_start", busy, 1);
      wait_for(0, "wait_kij3");
      start = 1'b1; oc_group = 1'b1;
      @(negedge clk);
      start = 1'b0; oc_group = 1'b0;
      check("start_busy_kij", cur_kij, 3);
      check("start_busy_busy", busy, 1);
      wait_for(1, "wait_done0");
      check("done0_kij", cur_kij, 8);

      // Run 1: start in the same cycle as done, oc_group 1
      start = 1'b1; oc_group = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("start_on_done", busy, 1);
      wait_for(1, "wait_done1");

      // Run 2: async reset in the middle of WLOAD
      @(negedge clk);
      start = 1'b1; oc_group = 1'b0;
      @(negedge clk);
      start = 1'b0;
      wait_for(2, "wait_wload");
      #1 reset = 1'b1;
      #1;
      check("midrst_inst", inst, IDLE_PAT);
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_kij", cur_kij, 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

`ifdef KIJ_SEQ_WATCHDOG_EN
      begin
         int last_exec, to_cyc;
         ofifo_en = 1'b0;
         last_exec = -1; to_cyc = -1;
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         for (int c = 0; c < 3000 && to_cyc < 0; c++) begin
            @(negedge clk);
            if (inst[1]) last_exec = c;
            if (timeout) begin
               to_cyc = c;
               check("wd_busy", busy, 0);
               check("wd_done", done, 0);
            end
         end
         check("wd_latency", to_cyc - last_exec, 513);
         @(negedge clk);
         check("wd_pulse", timeout, 0);
      end
`endif

      check("run2_no_done", n_done[2], 0);
      for (int r = 0; r < 2; r++) begin
         check($sformatf("r%0d_done_cnt", r), n_done[r], 1);
         check($sformatf("r%0d_done_kij", r), done_kij[r], 8);
         check($sformatf("r%0d_done_busy", r), done_busy[r], 0);
         for (int k = 0; k < 9; k++) begin
            check($sformatf("r%0d_k%0d_wl0", r, k), n_wl0[r][k], 10);
            check($sformatf("r%0d_k%0d_wload", r, k), n_wload[r][k], 17);
            check($sformatf("r%0d_k%0d_load", r, k), n_load[r][k], 16);
            check($sformatf("r%0d_k%0d_gap", r, k), n_gap[r][k], 11);
            check($sformatf("r%0d_k%0d_exec", r, k), n_exec[r][k], 37);
            check($sformatf("r%0d_k%0d_execute", r, k), n_execute[r][k], 36);
            check($sformatf("r%0d_k%0d_rd", r, k), n_rd[r][k], 36);
            check($sformatf("r%0d_k%0d_wr", r, k), n_wr[r][k], 16);
            check($sformatf("r%0d_k%0d_flush", r, k), n_flush[r][k], 3);
            check($sformatf("r%0d_k%0d_axbase", r, k), ax0[r][k], 1024 + 8 * k);
         end
         mask = 0; bad = 0; base = 32 * r;
         for (int n = 0; n < 36; n++) begin
            if (dw[r][0][n]) begin
               if (da[r][0][n] >= base && da[r][0][n] < base + 16)
                  mask = mask | (1 << (da[r][0][n] - base));
               else bad++;
               if (!dsfu[r][0][n] || dacc[r][0][n]) bad++;
            end
         end
         check($sformatf("r%0d_k0_addr_mask", r), mask, 32'hFFFF);
         check($sformatf("r%0d_k0_bad", r), bad, 0);
      end
      check("k2_axbase", ax0[0][2], 1040);

      for (int i = 0; i < 18; i++) begin
         check($sformatf("vec%0d_wr", i), dw[vecs[i].run][vecs[i].kij][vecs[i].nij], vecs[i].wr);
         if (vecs[i].wr) begin
            check($sformatf("vec%0d_addr", i), da[vecs[i].run][vecs[i].kij][vecs[i].nij], vecs[i].addr);
            check($sformatf("vec%0d_sfu", i), dsfu[vecs[i].run][vecs[i].kij][vecs[i].nij],
                  (vecs[i].kij == 0) ? 1 : 0);
            check($sformatf("vec%0d_acc", i), dacc[vecs[i].run][vecs[i].kij][vecs[i].nij],
                  (vecs[i].kij == 0) ? 0 : 1);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
